// File: rtl/rr_bus_arbiter.sv
// N-requester bus arbiter: fixed-priority or round-robin selection, grant hold
// while the holder keeps requesting, and an optional hold limit that forces rotation.

module rr_bus_arbiter_lane #(
    parameter int IDX  = 0,
    parameter int ID_W = 2
) (
    input  logic            req,
    input  logic            held,
    input  logic [ID_W-1:0] ptr,
    output logic            cand,
    output logic            cand_hi
);
    localparam logic [ID_W-1:0] LANE_ID = ID_W'(IDX);

    // The current holder never competes; a fresh grant always goes elsewhere.
    assign cand    = req & ~held;
    assign cand_hi = cand & (LANE_ID >= ptr);
endmodule

module rr_bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid
);
    localparam int HC_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic {IDLE, OWNED} state_t;

    typedef struct packed {
        logic [NUM_REQ-1:0] oh;
        logic [ID_W-1:0]    id;
    } arb_t;

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    ptr_eff;
    logic [ID_W-1:0]    ptr_nxt;
    logic [HC_W-1:0]    hold_cnt;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] cand_hi;
    logic [NUM_REQ-1:0] pick_hi;
    logic [NUM_REQ-1:0] pick_lo;
    arb_t               win;
    logic               holder_req;
    logic               force_rot;
    logic               rearb;

    // Fixed priority is round-robin with the search origin pinned at 0.
    assign ptr_eff = (RR_MODE != 0) ? ptr : '0;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        rr_bus_arbiter_lane #(
            .IDX  (i),
            .ID_W (ID_W)
        ) u_lane (
            .req     (req[i]),
            .held    (grant[i]),
            .ptr     (ptr_eff),
            .cand    (cand[i]),
            .cand_hi (cand_hi[i])
        );
    end

    // Lowest set bit of the upper window, falling back to the wrapped window.
    assign pick_hi = cand_hi & (~cand_hi + ONE);
    assign pick_lo = cand & (~cand + ONE);

    always_comb begin
        win.oh = (|cand_hi) ? pick_hi : pick_lo;
        win.id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win.oh[i]) win.id = win.id | ID_W'(i);
        end
    end

    assign ptr_nxt    = (win.id == ID_W'(NUM_REQ - 1)) ? '0 : win.id + ID_W'(1);
    assign holder_req = |(req & grant);
    assign force_rot  = (RR_MODE != 0) && (MAX_HOLD > 0) && (hold_cnt == HOLD_LAST) && (|cand);
    assign rearb      = (state == IDLE) || !holder_req || force_rot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            hold_cnt    <= '0;
            ptr         <= '0;
        end else begin
            if (rearb && (|cand)) begin
                state       <= OWNED;
                grant       <= win.oh;
                grant_id    <= win.id;
                grant_valid <= 1'b1;
                hold_cnt    <= '0;
                ptr         <= ptr_nxt;
            end else if (state == OWNED && !holder_req) begin
                state       <= IDLE;
                grant       <= '0;
                grant_id    <= '0;
                grant_valid <= 1'b0;
                hold_cnt    <= '0;
            end else if (state == OWNED && hold_cnt < HOLD_LAST) begin
                hold_cnt <= hold_cnt + HC_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants, monitors pop and compare.

module tb_rr_bus_arbiter;
    localparam int RR = 0;
    localparam int FX = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req_rr = 4'b0000;
    logic [3:0] req_fx = 4'b0000;
    logic [3:0] grant_rr, grant_fx;
    logic [1:0] id_rr, id_fx;
    logic       gv_rr, gv_fx;

    typedef struct {
        int         dut;
        int         step;
        logic [3:0] g;
        logic       v;
        logic [1:0] id;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step  = 0;
    event async_ev;

    always #5 clk = ~clk;

    rr_bus_arbiter #(.NUM_REQ(4), .RR_MODE(1), .MAX_HOLD(4)) u_rr (
        .clk(clk), .rst(rst), .req(req_rr),
        .grant(grant_rr), .grant_id(id_rr), .grant_valid(gv_rr)
    );

    rr_bus_arbiter #(.NUM_REQ(4), .RR_MODE(0), .MAX_HOLD(4)) u_fx (
        .clk(clk), .rst(rst), .req(req_fx),
        .grant(grant_fx), .grant_id(id_fx), .grant_valid(gv_fx)
    );

    function automatic logic [1:0] oh2id(input logic [3:0] g);
        logic [1:0] r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic push(input int d, input logic [3:0] eg);
        exp_t e;
        e.dut  = d;
        e.step = step;
        e.g    = eg;
        e.v    = |eg;
        e.id   = oh2id(eg);
        q.push_back(e);
        step++;
    endtask

    task automatic cyc(input int d, input logic rn, input logic [3:0] r, input logic [3:0] eg);
        @(negedge clk);
        rst = rn;
        if (d == RR) req_rr = r; else req_fx = r;
        push(d, eg);
    endtask

    task automatic rep(input int d, input logic [3:0] r, input logic [3:0] eg, input int n);
        for (int i = 0; i < n; i++) cyc(d, 1'b1, r, eg);
    endtask

    task automatic check_one();
        exp_t       e;
        logic [3:0] ag;
        logic       av;
        logic [1:0] aid;
        if (q.size() == 0) return;
        e   = q.pop_front();
        ag  = (e.dut == RR) ? grant_rr : grant_fx;
        av  = (e.dut == RR) ? gv_rr    : gv_fx;
        aid = (e.dut == RR) ? id_rr    : id_fx;
        n_cmp++;
        if (ag !== e.g || av !== e.v || (e.v && aid !== e.id)) begin
            n_bad++;
            $display("FAIL step%0d dut%0d: got grant=%b valid=%b id=%0d, want grant=%b valid=%b id=%0d",
                     e.step, e.dut, ag, av, aid, e.g, e.v, e.id);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        check_one();
    end

    always begin
        @(async_ev);
        #1;
        check_one();
    end

    initial begin
        // reset held with all requests high, then first grant to 0
        for (int i = 0; i < 5; i++) cyc(RR, 1'b0, 4'b1111, 4'b0000);
        cyc(RR, 1'b1, 4'b1111, 4'b0001);
        rep(RR, 4'b1111, 4'b0001, 3);
        rep(RR, 4'b1111, 4'b0010, 4);
        rep(RR, 4'b1111, 4'b0100, 4);
        rep(RR, 4'b1111, 4'b1000, 4);
        rep(RR, 4'b1111, 4'b0001, 1);

        // sole requester keeps the grant past the limit, rotation once another arrives
        rep(RR, 4'b0100, 4'b0100, 10);
        rep(RR, 4'b0101, 4'b0001, 1);

        // holder 1 drops as req[3] rises: no idle cycle
        rep(RR, 4'b0010, 4'b0010, 2);
        rep(RR, 4'b1000, 4'b1000, 1);
        rep(RR, 4'b0000, 4'b0000, 2);

        // re-grant after idle starts a fresh hold window
        rep(RR, 4'b1000, 4'b1000, 1);
        rep(RR, 4'b1001, 4'b1000, 3);
        rep(RR, 4'b1001, 4'b0001, 1);
        rep(RR, 4'b0000, 4'b0000, 1);

        // fixed priority: lowest index, no rotation, no preemption
        rep(FX, 4'b1100, 4'b0100, 7);
        rep(FX, 4'b1101, 4'b0100, 2);
        rep(FX, 4'b1001, 4'b0001, 1);
        rep(FX, 4'b1000, 4'b1000, 1);
        rep(FX, 4'b0000, 4'b0000, 1);

        // asynchronous reset mid-grant, pointer restarts at 0
        rep(RR, 4'b1100, 4'b0100, 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        push(RR, 4'b0000);
        ->async_ev;
        cyc(RR, 1'b0, 4'b1010, 4'b0000);
        cyc(RR, 1'b0, 4'b1010, 4'b0000);
        cyc(RR, 1'b1, 4'b1010, 4'b0010);
        cyc(RR, 1'b1, 4'b0000, 4'b0000);

        repeat (2) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Parametrised N-requester bus arbiter; successor to the two-master fixed-priority arbiter.
- Sits between bus masters and the shared peripheral bus; grant[i] gates master i's wr_en/rd_en onto the shared bus.
- Adds:
  - generic requester count;
  - selectable fixed-priority or round-robin mode;
  - grant hold while the request stays high;
  - a hold-time limit that forces rotation so no master starves.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- RR_MODE, 1: 1 = round-robin, 0 = fixed priority (index 0 highest).
- MAX_HOLD, 8: maximum consecutive grant cycles per holder when others wait (RR_MODE=1 only); 0 disables the limit.
- ID_W, $clog2(NUM_REQ): width of grant_id (localparam).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-low.
- req  input  NUM_REQ  per-master request, level-sensitive.
- grant  output  NUM_REQ  one-hot grant, registered.
- grant_id  output  ID_W  index of current holder; valid only when grant_valid=1.
- grant_valid  output  1  high when any grant is active (equals |grant).

Behaviour:
- Reset (rst=0, asynchronous):
  - grant=0, grant_id=0, grant_valid=0, hold_cnt=0.
  - RR pointer = 0: requester 0 is searched first after reset.
- States:
  - IDLE: no grant.
  - OWNED: exactly one grant bit set.
- IDLE -> OWNED: at the first rising edge where req != 0. The grant appears after that edge (1-cycle latency from req sampled high).
- Winner selection:
  - Fixed mode: lowest-index asserted req.
  - RR mode: search upward from pointer, wrapping at NUM_REQ-1 -> 0. The first asserted req wins.
  - After each new grant, pointer = winner+1, wrapping to 0.
- OWNED, holder req still high and no forced rotation: grant held, hold_cnt increments, saturating at MAX_HOLD-1.
- OWNED, holder req sampled low at an edge:
  - If other reqs are asserted, re-arbitrate at that same edge and hand the grant to the new winner with no idle cycle.
  - Otherwise go to IDLE; grant=0 after that edge.
- Forced rotation (RR_MODE=1, MAX_HOLD>0):
  - Triggers when hold_cnt==MAX_HOLD-1 and any other req is high.
  - At the next edge the grant moves to the next RR winner, excluding the current holder.
  - Net effect: the holder keeps the grant exactly MAX_HOLD cycles.
- Sole requester at the limit: holder keeps the grant; hold_cnt stays saturated until another req arrives. Rotation then happens at the next edge.
- hold_cnt:
  - Cleared to 0 on every new grant, including a re-grant to the same index after IDLE.
  - Reset to 0 in IDLE.
- Fixed mode:
  - No forced rotation.
  - A higher-priority req does not preempt an active holder. Priority applies only at arbitration points (IDLE, holder release).
- Invariants:
  - grant is always one-hot or zero.
  - A grant is never given to a requester whose req was low at the deciding edge.
- Simultaneous events: holder drop and new request at the same edge resolve as a normal re-arbitration among all asserted reqs, holder excluded.
- Reset mid-grant: outputs clear immediately, without waiting for a clock edge. Arbitration restarts from pointer 0 after rst is released.

Test Plan (NUM_REQ=4, MAX_HOLD=4):
- Reset held 5 cycles with req=4'b1111 -> grant=0, grant_valid=0 throughout. First edge after release -> grant=4'b0001, grant_id=0.
- RR_MODE=1, req=4'b1111 held, never dropped -> grant sequence 0001,0010,0100,1000,0001, each held exactly 4 cycles. No gap cycles, never two bits set.
- RR_MODE=1, only req[2] high for 10 cycles -> grant=4'b0100 for all 10 cycles, no rotation. Raise req[0] on cycle 11 -> grant moves to 4'b0001 at the next edge.
- Holder 1 drops req at the same edge req[3] rises, req[0] low -> grant 0010 -> 1000 on that edge, grant_valid stays 1. Then all req drop -> grant=0 next edge.
- RR_MODE=0, req=4'b1100 -> grant=1000? no: lowest index wins, so grant=0100. Raise req[0] while req[2] holds -> grant stays 0100 (no preemption). Drop req[2] -> grant=0001 at that edge.
- Assert rst mid-grant between clock edges -> grant and grant_valid go to 0 before the next edge. After release with req=4'b1010 -> grant=0010 (pointer restarted at 0).
